// File: rtl/rect_fill_if.sv
// Bus between a drawing sequencer (master) and the rectangle fill engine (slave).
// Optional outline/border_colour signals exist only when RECT_OUTLINE_EN is defined.
interface rect_fill_if #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int SIZE_W = 5
);
  logic              start;
  logic [X_W-1:0]    x0;
  logic [Y_W-1:0]    y0;
  logic [SIZE_W-1:0] w;
  logic [SIZE_W-1:0] h;
  logic [2:0]        colour_in;
`ifdef RECT_OUTLINE_EN
  logic              outline;
  logic [2:0]        border_colour;
`endif
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [2:0]        colour;
  logic              plot;
  logic              busy;
  logic              done;

`ifdef RECT_OUTLINE_EN
  modport master (output start, x0, y0, w, h, colour_in, outline, border_colour,
                  input  x, y, colour, plot, busy, done);
  modport slave  (input  start, x0, y0, w, h, colour_in, outline, border_colour,
                  output x, y, colour, plot, busy, done);
`else
  modport master (output start, x0, y0, w, h, colour_in,
                  input  x, y, colour, plot, busy, done);
  modport slave  (input  start, x0, y0, w, h, colour_in,
                  output x, y, colour, plot, busy, done);
`endif
endinterface

// File: rtl/rect_fill_engine.sv
// Raster-order rectangle pixel generator for the VGA adapter, one pixel per clock.
// Optional border drawing is enabled with the RECT_OUTLINE_EN macro.
module rect_fill_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SIZE_W   = 5,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  rect_fill_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2} state_t;

  localparam logic [X_W:0]      X_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]      Y_LIM = (Y_W+1)'(SCREEN_H);
  localparam logic [SIZE_W-1:0] ONE   = {{(SIZE_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [X_W-1:0]    x0_r, x0_s;
  logic [Y_W-1:0]    y0_r, y0_s;
  logic [SIZE_W-1:0] w_r, w_s, h_r, h_s;
  logic [2:0]        fill_r, fill_s;
  logic [SIZE_W-1:0] col_r, col_s, row_r, row_s;
  logic              load_s, emit_s, last_s;
  logic [X_W:0]      x_sum_s;
  logic [Y_W:0]      y_sum_s;
  logic [2:0]        pix_colour_s;
  logic [X_W-1:0]    x_r;
  logic [Y_W-1:0]    y_r;
  logic [2:0]        colour_r;
  logic              plot_r, busy_r, done_r;
`ifdef RECT_OUTLINE_EN
  logic              outline_r, outline_s;
  logic [2:0]        border_r, border_s;

  function automatic logic on_edge(input logic [SIZE_W-1:0] col, input logic [SIZE_W-1:0] row,
                                   input logic [SIZE_W-1:0] w,   input logic [SIZE_W-1:0] h);
    return (col == '0) || (col == w - ONE) || (row == '0) || (row == h - ONE);
  endfunction
`endif

  // Next-state, pixel counter advance and next-pixel computation
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    emit_s  = 1'b0;
    col_s   = col_r;
    row_s   = row_r;
    last_s  = (col_r == w_r - ONE) && (row_r == h_r - ONE);
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          load_s = 1'b1;
          col_s  = '0;
          row_s  = '0;
          if ((bus.w == '0) || (bus.h == '0)) begin
            state_s = DONE;
          end else begin
            state_s = DRAW;
            emit_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DRAW: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          emit_s = 1'b1;
          if (col_r == w_r - ONE) begin
            col_s = '0;
            row_s = row_r + ONE;
          end else begin
            col_s = col_r + ONE;
          end
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    // The first pixel is produced on the accepting edge, so it uses the live operands
    if (load_s) begin
      x0_s   = bus.x0;
      y0_s   = bus.y0;
      w_s    = bus.w;
      h_s    = bus.h;
      fill_s = bus.colour_in;
    end else begin
      x0_s   = x0_r;
      y0_s   = y0_r;
      w_s    = w_r;
      h_s    = h_r;
      fill_s = fill_r;
    end

    x_sum_s = {1'b0, x0_s} + {{(X_W+1-SIZE_W){1'b0}}, col_s};
    y_sum_s = {1'b0, y0_s} + {{(Y_W+1-SIZE_W){1'b0}}, row_s};

`ifdef RECT_OUTLINE_EN
    if (load_s) begin
      outline_s = bus.outline;
      border_s  = bus.border_colour;
    end else begin
      outline_s = outline_r;
      border_s  = border_r;
    end
    if (outline_s && on_edge(col_s, row_s, w_s, h_s)) begin
      pix_colour_s = border_s;
    end else begin
      pix_colour_s = fill_s;
    end
`else
    pix_colour_s = fill_s;
`endif
  end

  // State, latched operands, counters and registered pixel outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      x0_r      <= '0;
      y0_r      <= '0;
      w_r       <= '0;
      h_r       <= '0;
      fill_r    <= 3'd0;
      col_r     <= '0;
      row_r     <= '0;
      x_r       <= '0;
      y_r       <= '0;
      colour_r  <= 3'd0;
      plot_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef RECT_OUTLINE_EN
      outline_r <= 1'b0;
      border_r  <= 3'd0;
`endif
    end else begin
      state_r   <= state_s;
      x0_r      <= x0_s;
      y0_r      <= y0_s;
      w_r       <= w_s;
      h_r       <= h_s;
      fill_r    <= fill_s;
      col_r     <= col_s;
      row_r     <= row_s;
`ifdef RECT_OUTLINE_EN
      outline_r <= outline_s;
      border_r  <= border_s;
`endif
      // Clipped pixels still occupy their cycle with plot low
      plot_r    <= emit_s && (x_sum_s < X_LIM) && (y_sum_s < Y_LIM);
      busy_r    <= emit_s;
      done_r    <= (state_s == DONE);
      if (emit_s) begin
        x_r      <= x_sum_s[X_W-1:0];
        y_r      <= y_sum_s[Y_W-1:0];
        colour_r <= pix_colour_s;
      end else begin
        x_r      <= x_r;
        y_r      <= y_r;
        colour_r <= colour_r;
      end
    end
  end

  assign bus.x      = x_r;
  assign bus.y      = y_r;
  assign bus.colour = colour_r;
  assign bus.plot   = plot_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed self-checking bench for rect_fill_engine (default build; RECT_OUTLINE_EN adds the border test).
module tb_rect_fill_engine;

  logic clk;
  logic reset_n;
  int   checks_r;
  int   failures_r;
  int   plots_r;
  int   busys_r;

  rect_fill_if #(.X_W(8), .Y_W(7), .SIZE_W(5)) bus_if ();

  rect_fill_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] x0, input logic [6:0] y0,
                       input logic [4:0] w, input logic [4:0] h, input logic [2:0] c);
    bus_if.start     = s;
    bus_if.x0        = x0;
    bus_if.y0        = y0;
    bus_if.w         = w;
    bus_if.h         = h;
    bus_if.colour_in = c;
  endtask

  initial begin
    checks_r   = 0;
    failures_r = 0;
    reset_n    = 1'b0;
    drive(1'b0, 8'd0, 7'd0, 5'd0, 5'd0, 3'd0);
`ifdef RECT_OUTLINE_EN
    bus_if.outline       = 1'b0;
    bus_if.border_colour = 3'd0;
`endif
    #23;
    reset_n = 1'b1;
    check_val("rst_x",     32'(bus_if.x), 32'd0);
    check_val("rst_y",     32'(bus_if.y), 32'd0);
    check_val("rst_plot",  32'(bus_if.plot), 32'd0);
    check_val("rst_busy",  32'(bus_if.busy), 32'd0);
    check_val("rst_done",  32'(bus_if.done), 32'd0);
    step();

    // Test 1: 3x2 at (50,30), colour 100
    drive(1'b1, 8'd50, 7'd30, 5'd3, 5'd2, 3'b100);
    step();
    bus_if.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_val("t1_plot",   32'(bus_if.plot), 32'd1);
      check_val("t1_busy",   32'(bus_if.busy), 32'd1);
      check_val("t1_done",   32'(bus_if.done), 32'd0);
      check_val("t1_x",      32'(bus_if.x), 32'(50 + (k % 3)));
      check_val("t1_y",      32'(bus_if.y), 32'(30 + (k / 3)));
      check_val("t1_colour", 32'(bus_if.colour), 32'd4);
      step();
    end
    check_val("t1_done_c7", 32'(bus_if.done), 32'd1);
    check_val("t1_busy_c7", 32'(bus_if.busy), 32'd0);
    check_val("t1_plot_c7", 32'(bus_if.plot), 32'd0);
    check_val("t1_hold_x",  32'(bus_if.x), 32'd52);
    step();
    check_val("t1_done_c8", 32'(bus_if.done), 32'd0);

    // Test 2: zero width
    drive(1'b1, 8'd10, 7'd10, 5'd0, 5'd5, 3'b010);
    step();
    bus_if.start = 1'b0;
    check_val("t2_done", 32'(bus_if.done), 32'd1);
    check_val("t2_plot", 32'(bus_if.plot), 32'd0);
    check_val("t2_busy", 32'(bus_if.busy), 32'd0);
    step();
    check_val("t2_done_c2", 32'(bus_if.done), 32'd0);
    check_val("t2_plot_c2", 32'(bus_if.plot), 32'd0);
    step();

    // Test 3: clipping at the bottom-right corner
    drive(1'b1, 8'd158, 7'd118, 5'd4, 5'd4, 3'b001);
    step();
    bus_if.start = 1'b0;
    plots_r = 0;
    busys_r = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus_if.plot) begin
        plots_r++;
        check_val("t3_x_in", 32'(bus_if.x >= 8'd158 && bus_if.x <= 8'd159), 32'd1);
        check_val("t3_y_in", 32'(bus_if.y >= 7'd118 && bus_if.y <= 7'd119), 32'd1);
      end
      if (bus_if.busy) busys_r++;
      check_val("t3_nodone", 32'(bus_if.done), 32'd0);
      step();
    end
    check_val("t3_plots", 32'(plots_r), 32'd4);
    check_val("t3_busys", 32'(busys_r), 32'd16);
    check_val("t3_done",  32'(bus_if.done), 32'd1);
    step();

    // Test 4: asynchronous reset mid-draw
    drive(1'b1, 8'd10, 7'd20, 5'd4, 5'd4, 3'b011);
    step();
    bus_if.start = 1'b0;
    step();
    step();
    check_val("t4_pre_busy", 32'(bus_if.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("t4_x",      32'(bus_if.x), 32'd0);
    check_val("t4_y",      32'(bus_if.y), 32'd0);
    check_val("t4_colour", 32'(bus_if.colour), 32'd0);
    check_val("t4_plot",   32'(bus_if.plot), 32'd0);
    check_val("t4_busy",   32'(bus_if.busy), 32'd0);
    step();
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check_val("t4_nodone", 32'(bus_if.done), 32'd0);
      step();
    end
    drive(1'b1, 8'd5, 7'd6, 5'd2, 5'd2, 3'b110);
    step();
    bus_if.start = 1'b0;
    check_val("t4_new_x",    32'(bus_if.x), 32'd5);
    check_val("t4_new_y",    32'(bus_if.y), 32'd6);
    check_val("t4_new_plot", 32'(bus_if.plot), 32'd1);
    step();
    step();
    step();
    check_val("t4_new_last_x", 32'(bus_if.x), 32'd6);
    check_val("t4_new_last_y", 32'(bus_if.y), 32'd7);
    step();
    check_val("t4_new_done", 32'(bus_if.done), 32'd1);
    step();

    // Test 5: start held high, 2x1 rectangles restart every 4 cycles
    drive(1'b1, 8'd0, 7'd0, 5'd2, 5'd1, 3'b101);
    for (int c = 1; c <= 10; c++) begin
      step();
      check_val("t5_busy", 32'(bus_if.busy), 32'((c % 4 == 1) || (c % 4 == 2)));
      check_val("t5_done", 32'(bus_if.done), 32'(c % 4 == 3));
    end
    bus_if.start = 1'b0;
    step();
    check_val("t5_tail_done", 32'(bus_if.done), 32'd1);
    step();
    check_val("t5_idle_busy", 32'(bus_if.busy), 32'd0);

`ifdef RECT_OUTLINE_EN
    // Test 6: 3x3 outlined square, only the centre uses the fill colour
    drive(1'b1, 8'd20, 7'd20, 5'd3, 5'd3, 3'b001);
    bus_if.outline       = 1'b1;
    bus_if.border_colour = 3'b111;
    step();
    bus_if.start   = 1'b0;
    bus_if.outline = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check_val("t6_colour", 32'(bus_if.colour), (k == 4) ? 32'd1 : 32'd7);
      step();
    end
    check_val("t6_done", 32'(bus_if.done), 32'd1);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
